// File: rtl/ysyx_pkg.sv
// Shared types and constants for the ysyx instruction fetch unit.
// Holds the fetch FSM state encoding, the NOP encoding and the default boot PC.
package ysyx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, loads d when load is high.
module ysyx_pc_reg
    import ysyx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word for decode.
// Optional misaligned-PC trap path enabled by defining YSYX_IFU_MISALIGN_CHECK_EN.
module ysyx_ifu
    import ysyx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    output logic            inst_misalign,
`endif
    output logic [XLEN-1:0] inst_pc
);

    ifu_state_t      state;
    ifu_state_t      state_next;
    logic            drop;
    logic            drop_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            pc_load;
    logic            misalign_now;
    logic            misalign_enter;
    logic            req_fire;
    logic            capture;

`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    assign misalign_now = (state == REQ) && (pc[1:0] != 2'b00);
`else
    assign misalign_now = 1'b0;
`endif

    // A misaligned PC never reaches memory; a redirect in that cycle still wins.
    assign misalign_enter = misalign_now && !redirect_valid;
    assign imem_req_valid = (state == REQ) && !misalign_now;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign capture        = (state == WAIT) && imem_rsp_valid && !drop && !redirect_valid;

    assign pc_load = redirect_valid || capture;
    assign pc_next = redirect_valid ? redirect_pc : pc + XLEN'(4);

    ysyx_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

    always_comb begin
        state_next = state;
        drop_next  = drop;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (req_fire) begin
                    state_next = WAIT;
                    drop_next  = redirect_valid;
                end else if (misalign_enter) begin
                    state_next = HOLD;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_next  = 1'b0;
                    state_next = capture ? HOLD : REQ;
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            HOLD: begin
                if (inst_ready || redirect_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    // inst/inst_pc only change on entry to HOLD, so they are stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= INST_NOP;
            inst_pc <= '0;
        end else if (capture) begin
            inst    <= imem_rsp_data;
            inst_pc <= pc;
        end else if (misalign_enter) begin
            inst    <= INST_NOP;
            inst_pc <= pc;
        end
    end

`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_misalign <= 1'b0;
        end else if (misalign_enter) begin
            inst_misalign <= 1'b1;
        end else if ((state == HOLD) && (state_next != HOLD)) begin
            inst_misalign <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: directed scenarios plus a randomized run
// against a transaction-level fetch model. Define YSYX_IFU_MISALIGN_CHECK_EN to cover the trap path.
module tb_ysyx_ifu;
    import ysyx_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    logic        inst_misalign;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_ifu #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
        .inst_misalign (inst_misalign),
`endif
        .inst_pc       (inst_pc)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (imem_req_valid === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic fetch_to_hold(input logic [31:0] data, output bit ok);
        bit got_req;
        wait_req(got_req);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        ok = got_req && (inst_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== INST_NOP) begin errors++; $display("[TB] FAIL reset_inst: got %h want %h", inst, INST_NOP); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %h want 0", inst_pc); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("[TB] FAIL reset_addr: got %h want %h", imem_req_addr, RST_PC); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_fetch();
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("[TB] FAIL basic_req: got valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_req_valid: got %b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0297;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_inst_valid: got %b want 1", inst_valid); end
        checks++; if (inst !== 32'h0000_0297) begin errors++; $display("[TB] FAIL basic_inst: got %h want 00000297", inst); end
        checks++; if (inst_pc !== RST_PC) begin errors++; $display("[TB] FAIL basic_inst_pc: got %h want %h", inst_pc, RST_PC); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin errors++; $display("[TB] FAIL basic_next_addr: got valid=%b addr=%h want 1 80000004", imem_req_valid, imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_consumed: got inst_valid=%b want 0", inst_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        fetch_to_hold(32'h0010_0093, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_reach_hold: got %b want 1", ok); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_stable: cycle %0d got v=%b inst=%h pc=%h req=%b want 1 00100093 80000004 0", i, inst_valid, inst, inst_pc, imem_req_valid);
            end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin errors++; $display("[TB] FAIL bp_release: got valid=%b addr=%h want 1 80000008", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rw_req: got %b want 1", ok); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_still_wait: got req=%b inst_valid=%b want 0 0", imem_req_valid, inst_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_dropped: got inst_valid=%b want 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin errors++; $display("[TB] FAIL rw_target: got valid=%b addr=%h want 1 80000100", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        fetch_to_hold(32'h0000_0517, ok);
        checks++; if (!ok || inst_pc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL rh_hold: got ok=%b pc=%h want 1 80000100", ok, inst_pc); end
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rh_consumed: got inst_valid=%b want 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin errors++; $display("[TB] FAIL rh_target: got valid=%b addr=%h want 1 80000200", imem_req_valid, imem_req_addr); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rh_once: got inst_valid=%b want 0", inst_valid); end
    endtask

    task automatic test_wrap();
        bit ok;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req: got valid=%b addr=%h want 1 fffffffc", imem_req_valid, imem_req_addr); end
        fetch_to_hold(32'h0000_8067, ok);
        checks++; if (!ok || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h0000_8067) begin errors++; $display("[TB] FAIL wrap_hold: got ok=%b pc=%h inst=%h want 1 fffffffc 00008067", ok, inst_pc, inst); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got valid=%b addr=%h want 1 00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        wait_req(ok);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== RST_PC || inst !== INST_NOP) begin errors++; $display("[TB] FAIL midrst_clear: got req=%b iv=%b addr=%h inst=%h want 0 0 %h %h", imem_req_valid, inst_valid, imem_req_addr, inst, RST_PC, INST_NOP); end
        tick();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("[TB] FAIL midrst_first_req: got valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_ignored: got inst_valid=%b want 0", inst_valid); end
    endtask

`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_req: got %b want 0", imem_req_valid); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst !== INST_NOP || inst_pc !== 32'h8000_0002 || inst_misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_hold: got v=%b inst=%h pc=%h mis=%b want 1 %h 80000002 1", inst_valid, inst, inst_pc, inst_misalign, INST_NOP); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0010;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        checks++; if (inst_misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin errors++; $display("[TB] FAIL mis_leave: got mis=%b req=%b addr=%h want 0 1 80000010", inst_misalign, imem_req_valid, imem_req_addr); end
    endtask
`endif

    // Model tracks fetches as transactions: expected next address, the one request in flight, and the held word.
    task automatic test_random();
        logic [31:0] exp_pc;
        bit          outstanding;
        bit          out_drop;
        logic [31:0] out_addr;
        bit          have_entry;
        logic [31:0] ent_data;
        logic [31:0] ent_pc;
        int          delivered;
        bit          accepted;
        bit          was_out;

        rst_n = 1'b0;
        redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_pc = RST_PC; outstanding = 0; out_drop = 0; out_addr = '0;
        have_entry = 0; ent_data = '0; ent_pc = '0; delivered = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (inst_valid !== have_entry) begin errors++; $display("[TB] FAIL rnd_inst_valid: cycle %0d got %b want %b", cyc, inst_valid, have_entry); end
            if (have_entry && inst_valid === 1'b1) begin
                checks++; if (inst !== ent_data || inst_pc !== ent_pc) begin errors++; $display("[TB] FAIL rnd_inst: cycle %0d got %h@%h want %h@%h", cyc, inst, inst_pc, ent_data, ent_pc); end
            end
            if (imem_req_valid === 1'b1) begin
                checks++; if (imem_req_addr !== exp_pc || outstanding) begin errors++; $display("[TB] FAIL rnd_req: cycle %0d got addr=%h outstanding=%b want %h 0", cyc, imem_req_addr, outstanding, exp_pc); end
            end

            imem_req_ready = ($urandom_range(0, 1) == 1);
            imem_rsp_valid = outstanding ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
            imem_rsp_data  = $urandom;
            inst_ready     = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};

            accepted = (imem_req_valid === 1'b1) && imem_req_ready;
            was_out  = outstanding;
            if (have_entry && (inst_ready || redirect_valid)) begin
                if (inst_ready) delivered++;
                have_entry = 0;
            end
            if (was_out && imem_rsp_valid) begin
                outstanding = 0;
                if (!out_drop && !redirect_valid) begin
                    have_entry = 1;
                    ent_data   = imem_rsp_data;
                    ent_pc     = out_addr;
                    exp_pc     = out_addr + 32'd4;
                end
            end else if (was_out && redirect_valid) begin
                out_drop = 1;
            end
            if (accepted) begin
                outstanding = 1;
                out_drop    = redirect_valid;
                out_addr    = imem_req_addr;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            tick();
        end
        redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
        checks++; if (delivered < 20) begin errors++; $display("[TB] FAIL rnd_progress: got %0d deliveries want at least 20", delivered); end
    endtask

    initial begin
        $display("[TB] ysyx_ifu bench start");
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_midop();
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
